// File: rtl/single_slope_adc_if.sv
// Result channel of the single-slope ADC: the sample register with its valid/ready
// handshake and the overflow qualifier.
interface single_slope_adc_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;
  logic             overflow;

  modport master (
    output sample,
    output sample_valid,
    output overflow,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    input  overflow,
    output sample_ready
  );
endinterface

// File: rtl/single_slope_adc.sv
// Single-slope ADC controller: discharges the ramp capacitor, counts while the ramp rises
// and captures the count when the synchronized comparator trips or the count hits full scale.
module single_slope_adc #(
  parameter int WIDTH            = 10,
  parameter int DISCHARGE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               comp_in,
  input  logic               run,
  output logic               ramp_discharge,
  output logic               busy,
  output logic               overrun,
  single_slope_adc_if.master res
);

  typedef enum logic [1:0] {IDLE, DISCHARGE, RAMP} state_t;

  localparam logic [WIDTH-1:0] FULL_SCALE = '1;
  localparam logic [15:0]      DIS_LAST   = 16'(DISCHARGE_CYCLES - 1);

  state_t           state, state_next;
  logic [15:0]      dis_cnt, dis_cnt_next;
  logic [WIDTH-1:0] conv_cnt, conv_cnt_next;
  logic             comp_meta, comp_s;
  logic             capture;
  logic             cap_ovf;
  logic [WIDTH-1:0] cap_value;

  // comp_in is asynchronous; the 2-cycle latency is intentionally left in the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_in;
      comp_s    <= comp_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dis_cnt  <= '0;
      conv_cnt <= '0;
    end else begin
      state    <= state_next;
      dis_cnt  <= dis_cnt_next;
      conv_cnt <= conv_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    dis_cnt_next  = dis_cnt;
    conv_cnt_next = conv_cnt;
    capture       = 1'b0;
    cap_ovf       = 1'b0;
    cap_value     = conv_cnt;
    unique case (state)
      IDLE: begin
        if (run) begin
          state_next   = DISCHARGE;
          dis_cnt_next = '0;
        end
      end
      DISCHARGE: begin
        if (dis_cnt == DIS_LAST) begin
          state_next    = RAMP;
          conv_cnt_next = '0;
        end else begin
          dis_cnt_next = dis_cnt + 16'd1;
        end
      end
      RAMP: begin
        conv_cnt_next = conv_cnt + 1'b1;
        if (comp_s) begin
          capture = 1'b1;
        end else if (conv_cnt == FULL_SCALE) begin
          capture = 1'b1;
          cap_ovf = 1'b1;
        end
        // run is only sampled here, so dropping it mid-conversion never aborts one
        if (capture) begin
          state_next   = run ? DISCHARGE : IDLE;
          dis_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ramp_discharge = (state != RAMP);
  assign busy           = (state != IDLE);

  // A full register that is not being drained drops the new result and flags overrun
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.sample       <= '0;
      res.overflow     <= 1'b0;
      res.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else if (capture) begin
      if (!res.sample_valid || res.sample_ready) begin
        res.sample       <= cap_value;
        res.overflow     <= cap_ovf;
        res.sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (res.sample_valid && res.sample_ready) begin
      res.sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_single_slope_adc.sv
// Directed bench for single_slope_adc (WIDTH=10, DISCHARGE_CYCLES=4) with hand-computed
// expectations; outputs are sampled on the falling clock edge.
module tb_single_slope_adc;

  logic clk;
  logic rst;
  logic comp_in;
  logic run;
  logic ramp_discharge;
  logic busy;
  logic overrun;
  int   total;
  int   bad;

  single_slope_adc_if #(.WIDTH(10)) res_if ();

  single_slope_adc #(
    .WIDTH(10),
    .DISCHARGE_CYCLES(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .comp_in        (comp_in),
    .run            (run),
    .ramp_discharge (ramp_discharge),
    .busy           (busy),
    .overrun        (overrun),
    .res            (res_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a falling edge before RAMP; returns at the falling edge of the first RAMP cycle
  task automatic wait_ramp(output int dis_cycles, output bit ok);
    dis_cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!ramp_discharge) begin
        ok = 1'b1;
        break;
      end
      if (busy) dis_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles, output bit ok);
    cycles = 0;
    while (!res_if.sample_valid && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    ok = res_if.sample_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    run = 1'b0;
    comp_in = 1'b0;
    res_if.sample_ready = 1'b1;
    #2;
    total++;
    if ({ramp_discharge, busy, res_if.sample_valid, res_if.overflow, overrun} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_flags got rd/busy/valid/ovf/ovr=%b want 10000",
               {ramp_discharge, busy, res_if.sample_valid, res_if.overflow, overrun});
    end
    total++;
    if (res_if.sample !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_sample got %0d want 0", res_if.sample);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ramp_discharge !== 1'b1) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got busy=%b rd=%b want busy=0 rd=1", busy, ramp_discharge);
    end
  endtask

  task automatic test_trip;
    int dc;
    int cyc;
    bit ok;
    run = 1'b1;
    wait_ramp(dc, ok);
    total++;
    if (!ok || dc != 4) begin
      bad++;
      $display("[TB] FAIL trip_discharge got %0d cycles (ok=%b) want 4", dc, ok);
    end
    repeat (99) @(negedge clk);
    comp_in = 1'b1;
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || res_if.sample !== 10'd101 || res_if.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL trip_sample got %0d ovf=%b (ok=%b) want 101 ovf=0", res_if.sample, res_if.overflow, ok);
    end
    comp_in = 1'b0;
    @(negedge clk);
    total++;
    if (res_if.sample_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL trip_valid_pulse got valid=%b want 0", res_if.sample_valid);
    end
  endtask

  task automatic test_full_scale;
    int dc;
    int cyc;
    bit ok;
    wait_ramp(dc, ok);
    wait_valid(1100, cyc, ok);
    total++;
    if (!ok || cyc != 1024 || res_if.sample !== 10'd1023 || res_if.overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL full_scale got %0d ovf=%b after %0d cycles want 1023 ovf=1 after 1024",
               res_if.sample, res_if.overflow, cyc);
    end
    wait_ramp(dc, ok);
    total++;
    if (!ok || dc != 4) begin
      bad++;
      $display("[TB] FAIL full_scale_next_discharge got %0d want 4", dc);
    end
  endtask

  // Entered at the falling edge of the first RAMP cycle left by test_full_scale
  task automatic test_run_drop;
    int cyc;
    bit ok;
    bit extra;
    run = 1'b0;
    comp_in = 1'b1;
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || cyc != 3 || res_if.sample !== 10'd2 || res_if.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL run_drop_sample got %0d after %0d cycles want 2 after 3", res_if.sample, cyc);
    end
    @(negedge clk);
    total++;
    if (res_if.sample_valid !== 1'b0 || busy !== 1'b0 || ramp_discharge !== 1'b1) begin
      bad++;
      $display("[TB] FAIL run_drop_idle got valid=%b busy=%b rd=%b want 0 0 1",
               res_if.sample_valid, busy, ramp_discharge);
    end
    extra = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_if.sample_valid || busy) extra = 1'b1;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++;
      $display("[TB] FAIL run_drop_stays_idle got activity=%b want 0", extra);
    end
  endtask

  task automatic test_comp_high;
    int dc;
    int cyc;
    bit ok;
    run = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_ramp(dc, ok);
      total++;
      if (!ok || dc != 4) begin
        bad++;
        $display("[TB] FAIL comp_high_discharge[%0d] got %0d want 4", n, dc);
      end
      wait_valid(20, cyc, ok);
      total++;
      if (!ok || res_if.sample !== 10'd0 || res_if.overflow !== 1'b0) begin
        bad++;
        $display("[TB] FAIL comp_high_sample[%0d] got %0d ovf=%b want 0 ovf=0", n, res_if.sample, res_if.overflow);
      end
    end
    run = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL comp_high_stop got busy=%b want 0", busy);
    end
    @(negedge clk);
    comp_in = 1'b0;
  endtask

  task automatic test_overrun;
    int dc;
    int cyc;
    bit ok;
    res_if.sample_ready = 1'b0;
    run = 1'b1;
    wait_ramp(dc, ok);
    repeat (9) @(negedge clk);
    comp_in = 1'b1;
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || res_if.sample !== 10'd11) begin
      bad++;
      $display("[TB] FAIL overrun_first got %0d want 11", res_if.sample);
    end
    comp_in = 1'b0;
    wait_ramp(dc, ok);
    run = 1'b0;
    repeat (19) @(negedge clk);
    comp_in = 1'b1;
    cyc = 0;
    while (!overrun && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (overrun !== 1'b1 || cyc != 3) begin
      bad++;
      $display("[TB] FAIL overrun_flag got %b after %0d cycles want 1 after 3", overrun, cyc);
    end
    total++;
    if (res_if.sample !== 10'd11 || res_if.sample_valid !== 1'b1 || res_if.overflow !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overrun_hold got %0d valid=%b ovf=%b busy=%b want 11 1 0 0",
               res_if.sample, res_if.sample_valid, res_if.overflow, busy);
    end
    res_if.sample_ready = 1'b1;
    comp_in = 1'b0;
    @(negedge clk);
    total++;
    if (res_if.sample_valid !== 1'b0 || overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_drain got valid=%b ovr=%b want 0 1", res_if.sample_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_ramp;
    int dc;
    int cyc;
    bit ok;
    run = 1'b1;
    wait_ramp(dc, ok);
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({ramp_discharge, busy, res_if.sample_valid, overrun} !== 4'b1000 || res_if.sample !== 10'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got rd/busy/valid/ovr=%b sample=%0d want 1000 sample=0",
               {ramp_discharge, busy, res_if.sample_valid, overrun}, res_if.sample);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ramp(dc, ok);
    total++;
    if (!ok || dc != 4) begin
      bad++;
      $display("[TB] FAIL reset_restart_discharge got %0d want 4", dc);
    end
    run = 1'b0;
    comp_in = 1'b1;
    wait_valid(20, cyc, ok);
    total++;
    if (!ok || res_if.sample !== 10'd2) begin
      bad++;
      $display("[TB] FAIL reset_restart_count got %0d want 2", res_if.sample);
    end
    comp_in = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_trip();
    test_full_scale();
    test_run_drop();
    test_comp_high();
    test_overrun();
    test_reset_mid_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/single_slope_adc.md
SINGLE_SLOPE_ADC -- requirements
Module: single_slope_adc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the conversion result width in bits.
REQ-002 The block SHALL have parameter DISCHARGE_CYCLES, default 64, giving the ramp-capacitor discharge time in clk cycles (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, the 6 MHz hf_osc domain.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port comp_in, input, 1 bit: raw LVDS comparator output (D_IN_0), asynchronous to clk, 1 when ramp > analog input.
REQ-006 The block SHALL have port run, input, 1 bit: level enable for back-to-back conversions.
REQ-007 The block SHALL have port ramp_discharge, output, 1 bit: 1 = external ramp capacitor shorted/held at 0 V.
REQ-008 The block SHALL have port busy, output, 1 bit: 1 whenever the FSM is not IDLE.
REQ-009 The block SHALL have port sample, output, WIDTH bits: the conversion result.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: the result-register-full flag.
REQ-011 The block SHALL have port sample_ready, input, 1 bit: consumer accept.
REQ-012 The block SHALL have port overflow, output, 1 bit: qualifies sample; 1 = ramp reached full scale with no comparator trip.
REQ-013 The block SHALL have port overrun, output, 1 bit: sticky flag; 1 = a result was dropped because the register was full.

Function
REQ-014 comp_in SHALL pass through a 2-flop synchronizer (comp_s); all logic SHALL use comp_s only.
REQ-015 FSM states SHALL be IDLE, DISCHARGE and RAMP, with the transitions defined in REQ-016 to REQ-020.
REQ-016 IDLE: ramp_discharge=1; when run=1, next state SHALL be DISCHARGE and the discharge counter SHALL load 0.
REQ-017 DISCHARGE: ramp_discharge=1; the counter SHALL increment each cycle; after exactly DISCHARGE_CYCLES cycles in DISCHARGE, next state SHALL be RAMP and the conversion counter SHALL clear to 0.
REQ-018 RAMP: ramp_discharge=0; the conversion counter (WIDTH bits) SHALL increment by 1 each cycle, starting at 0 in the first RAMP cycle.
REQ-019 RAMP trip: in the first RAMP cycle with comp_s=1, the block SHALL capture the current counter value as the result with overflow=0; there SHALL be no synchronizer-latency compensation, so the result includes the fixed 2-cycle offset.
REQ-020 RAMP full scale: if the counter equals 2^WIDTH-1 with comp_s=0, the block SHALL capture 2^WIDTH-1 with overflow=1.
REQ-021 After either capture, the next state SHALL be DISCHARGE when run=1 and IDLE when run=0.
REQ-022 Deasserting run during DISCHARGE or RAMP SHALL NOT abort the conversion; the conversion SHALL complete and the block SHALL then go to IDLE.
REQ-023 comp_s=1 already in the first RAMP cycle SHALL capture 0.
REQ-024 Output register when empty: a capture SHALL load sample/overflow and set sample_valid on the next edge (1-cycle latency from the capture cycle).
REQ-025 The transfer SHALL occur on a clk edge with sample_valid=1 and sample_ready=1; sample_valid SHALL clear that edge unless a capture occurs in the same cycle.
REQ-026 A capture coinciding with a transfer SHALL load the new result, and sample_valid SHALL stay 1 with no overrun.
REQ-027 A capture while sample_valid=1 and sample_ready=0 SHALL drop the new result, keep the old sample/overflow, and set overrun; the FSM SHALL continue regardless.
REQ-028 sample and overflow SHALL be stable while sample_valid=1 and not accepted.
REQ-029 overrun SHALL clear only on reset.
REQ-030 busy SHALL be 1 in DISCHARGE and RAMP, and 0 in IDLE.

Reset
REQ-031 On rst=1, immediately and asynchronously: state=IDLE, ramp_discharge=1, busy=0, sample=0, sample_valid=0, overflow=0, overrun=0, counters=0, synchronizer flops=0.
REQ-032 A reset mid-conversion SHALL discard the partial count; after rst falls, the block SHALL restart from IDLE with a full DISCHARGE before any RAMP.

Verification
REQ-033 WIDTH=10, DISCHARGE_CYCLES=4, run=1, comp_in rises 100 cycles after RAMP entry, sample_ready=1 -> sample=101 (100 + 2-cycle sync offset - 1 because counting starts at 0), sample_valid pulses 1 cycle, overflow=0.
REQ-034 comp_in held 0 -> capture after 1023 RAMP cycles: sample=1023, overflow=1; next conversion begins with 4 DISCHARGE cycles.
REQ-035 sample_ready=0 across two completed conversions -> first result held, overrun=1 after the second capture; then sample_ready=1 -> first result transfers, sample_valid=0 next cycle.
REQ-036 rst asserted mid-RAMP, asynchronously between edges -> ramp_discharge=1 and busy=0 without a clock edge; after release with run=1, exactly DISCHARGE_CYCLES discharge cycles precede counting.
REQ-037 run dropped mid-RAMP -> conversion completes, one sample delivered, FSM IDLE, busy=0, ramp_discharge=1.
REQ-038 comp_in=1 throughout -> sample=0, overflow=0 each conversion.
